// File: rtl/axi2apb_ctrl.sv
// rtl/axi2apb_ctrl.sv - APB master sequencer: one command at a time through SETUP/ACCESS, one response beat back
// Wait-state timeout abandons a stuck ACCESS phase and reports it as an error response.
module axi2apb_ctrl #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [31:0]               cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      pwrite,
    output logic [31:0]               pwdata,
    output logic                      penable,
    output logic                      ctrl_psel,
    output logic [3:0]                ctrl_addr_mux,
    input  logic                      ctrl_pready,
    input  logic                      ctrl_pslverr,
    input  logic [31:0]               ctrl_prdata
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_psel;
    logic                      r_penable;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic                      r_pwrite;
    logic [31:0]               r_pwdata;
    logic [3:0]                r_addr_mux;
    logic                      r_rsp_valid;
    logic [31:0]               r_rsp_rdata;
    logic                      r_rsp_err;
    logic [CNT_W-1:0]          r_cnt;

    logic w_timeout;
    logic w_cnt_max;

    // pready in the last allowed wait cycle still completes normally
    assign w_timeout = TO_EN && !ctrl_pready && (r_cnt == TO_LAST);
    assign w_cnt_max = &r_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_addr_mux  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_paddr    <= cmd_addr[APB_ADDR_WIDTH-1:0];
                        r_pwrite   <= cmd_write;
                        r_pwdata   <= cmd_wdata;
                        r_addr_mux <= cmd_addr[SEL_LSB+3:SEL_LSB];
                        r_psel     <= 1'b1;
                        r_penable  <= 1'b0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (ctrl_pready) begin
                        r_rsp_err   <= ctrl_pslverr;
                        r_rsp_rdata <= (!r_pwrite && !ctrl_pslverr) ? ctrl_prdata : 32'd0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (!w_cnt_max) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;
    assign paddr         = r_paddr;
    assign pwrite        = r_pwrite;
    assign pwdata        = r_pwdata;
    assign penable       = r_penable;
    assign ctrl_psel     = r_psel;
    assign ctrl_addr_mux = r_addr_mux;

endmodule

// File: tb/tb_axi2apb_ctrl.sv
// tb/tb_axi2apb_ctrl.sv - scoreboard bench for axi2apb_ctrl with an 8-slave APB mux/slave model
module tb_axi2apb_ctrl;

    localparam int TO = 8;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        penable;
    logic        ctrl_psel;
    logic [3:0]  ctrl_addr_mux;
    logic        ctrl_pready = 1'b0;
    logic        ctrl_pslverr = 1'b0;
    logic [31:0] ctrl_prdata = 32'd0;

    axi2apb_ctrl #(
        .APB_ADDR_WIDTH(32),
        .SEL_LSB(12),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .paddr(paddr),
        .pwrite(pwrite),
        .pwdata(pwdata),
        .penable(penable),
        .ctrl_psel(ctrl_psel),
        .ctrl_addr_mux(ctrl_addr_mux),
        .ctrl_pready(ctrl_pready),
        .ctrl_pslverr(ctrl_pslverr),
        .ctrl_prdata(ctrl_prdata)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          w;
        logic        slverr;
        logic [31:0] prd;
    } plan_t;

    typedef struct {
        plan_t       p;
        logic        dec;
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          rsp_cyc;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    exp_t  slv_q[$];
    exp_t  m_e;
    exp_t  m_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seen = 1'b0;
    bit slv_active = 1'b0;
    int slv_cnt = 0;
    bit rdy_random = 1'b0;
    bit stall_arm = 1'b0;
    int stall_cnt = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // response consumer
    always @(posedge ACLK) begin
        #1;
        if (!stall_arm) stall_cnt = 0;
        if (stall_arm && rsp_valid && stall_cnt < 5) begin
            rsp_ready = 1'b0;
            stall_cnt++;
        end else begin
            rsp_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // monitor, scoreboard and APB mux/slave model
    always @(negedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            #1;
            chk("reset psel", 32'(ctrl_psel), 32'd0);
            chk("reset penable", 32'(penable), 32'd0);
            chk("reset paddr", paddr, 32'd0);
            chk("reset pwrite", 32'(pwrite), 32'd0);
            chk("reset pwdata", pwdata, 32'd0);
            chk("reset addr_mux", 32'(ctrl_addr_mux), 32'd0);
            chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
            chk("reset rsp_err", 32'(rsp_err), 32'd0);
            chk("reset rsp_rdata", rsp_rdata, 32'd0);
            chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
            exp_q.delete();
            slv_q.delete();
            seen = 1'b0;
            slv_active = 1'b0;
            ctrl_pready = 1'b0;
            ctrl_pslverr = 1'b0;
        end else begin
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() == 0));
            if (exp_q.size() == 0) begin
                chk("idle rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                m_e = exp_q[0];
                if (cyc == m_e.acc + 1) begin
                    chk("setup psel", 32'(ctrl_psel), 32'd1);
                    chk("setup penable", 32'(penable), 32'd0);
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        chk("rsp latency", 32'(cyc), 32'(m_e.rsp_cyc));
                        chk("psel after done", 32'(ctrl_psel), 32'd0);
                        chk("penable after done", 32'(penable), 32'd0);
                        seen = 1'b1;
                    end
                    chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
                    chk("rsp_rdata", rsp_rdata, m_e.rdata);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end else if (seen || cyc >= m_e.rsp_cyc) begin
                    chk("rsp_valid present", 32'(rsp_valid), 32'd1);
                end
            end

            if (cmd_valid && cmd_ready) begin
                chk("plan available", 32'(plan_q.size() != 0), 32'd1);
                if (plan_q.size() != 0) begin
                    m_n.p = plan_q.pop_front();
                    m_n.dec = ((m_n.p.addr >> 12) & 32'hF) >= 8;
                    m_n.err = m_n.dec || (m_n.p.w >= TO) || m_n.p.slverr;
                    m_n.rdata = (m_n.p.wr || m_n.err) ? 32'd0 : m_n.p.prd;
                    m_n.acc = cyc;
                    m_n.rsp_cyc = cyc + 3 + (m_n.dec ? 0 : ((m_n.p.w >= TO) ? TO - 1 : m_n.p.w));
                    exp_q.push_back(m_n);
                    slv_q.push_back(m_n);
                end
            end

            if (ctrl_psel && penable) begin
                chk("apb access expected", 32'(slv_q.size() != 0), 32'd1);
                if (slv_q.size() != 0) begin
                    m_e = slv_q[0];
                    chk("paddr", paddr, m_e.p.addr);
                    chk("pwrite", 32'(pwrite), 32'(m_e.p.wr));
                    chk("addr_mux", 32'(ctrl_addr_mux), (m_e.p.addr >> 12) & 32'hF);
                    if (m_e.p.wr) chk("pwdata", pwdata, m_e.p.wdata);
                    if (!slv_active) begin
                        slv_active = 1'b1;
                        slv_cnt = 0;
                    end
                    if (m_e.dec || slv_cnt == m_e.p.w) begin
                        ctrl_pready = 1'b1;
                        ctrl_pslverr = m_e.dec || m_e.p.slverr;
                        ctrl_prdata = m_e.p.prd;
                    end else begin
                        ctrl_pready = 1'b0;
                        ctrl_pslverr = 1'($urandom_range(0, 1));
                        ctrl_prdata = $urandom;
                    end
                    slv_cnt++;
                end
            end else begin
                ctrl_pready = 1'b0;
                ctrl_pslverr = 1'b0;
                if (slv_active) begin
                    void'(slv_q.pop_front());
                    slv_active = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input logic slverr, input logic [31:0] prd);
        plan_t p;
        bit    got;
        p.wr = wr;
        p.addr = addr;
        p.wdata = wdata;
        p.w = w;
        p.slverr = slverr;
        p.prd = prd;
        plan_q.push_back(p);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_wdata = wdata;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge ACLK);
            if (cmd_ready) got = 1'b1;
        end
        if (!got) begin
            $display("FAIL cmd accept: got no cmd_ready expected accept within 300 cycles");
            $fatal(1, "accept bound expired");
        end
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr = $urandom;
        cmd_wdata = $urandom;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge ACLK);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
            $fatal(1, "drain bound expired");
        end
    endtask

    initial begin
        logic [31:0] a;
        int          w;
        int          r;
        int          gap;
        bit          got;

        #3 ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        #2 ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        rdy_random = 1'b0;
        issue(1'b1, 32'h0000_2010, 32'hDEADBEEF, 0, 1'b0, $urandom);
        drain();
        issue(1'b0, 32'h0000_1004, $urandom, 3, 1'b0, 32'hCAFEF00D);
        drain();
        issue(1'b0, 32'h0000_9000, $urandom, 0, 1'b0, $urandom);
        drain();
        issue(1'b0, 32'h0000_2000, $urandom, 1, 1'b1, 32'hAAAA5555);
        drain();
        issue(1'b0, 32'h0000_3000, $urandom, 100, 1'b0, $urandom);
        drain();
        issue(1'b0, 32'h0000_3004, $urandom, TO - 1, 1'b0, 32'h0BADF00D);
        drain();

        stall_arm = 1'b1;
        issue(1'b0, 32'h0000_3008, $urandom, 0, 1'b0, 32'h12345678);
        issue(1'b1, 32'h0000_4000, 32'h55AA55AA, 0, 1'b0, $urandom);
        drain();
        stall_arm = 1'b0;

        rdy_random = 1'b1;
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[15] = 1'b0;
            r = $urandom_range(0, 9);
            w = (r < 6) ? r % 4 : (r == 6) ? TO - 1 : (r == 7) ? TO + $urandom_range(0, 4) : 0;
            issue(1'($urandom_range(0, 1)), a, $urandom, w, ($urandom_range(0, 7) == 0), $urandom);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                repeat (gap) @(posedge ACLK);
                #1;
            end
        end
        drain();

        rdy_random = 1'b0;
        issue(1'b0, 32'h0000_5000, $urandom, 5, 1'b0, $urandom);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge ACLK);
            if (penable) got = 1'b1;
        end
        if (!got) begin
            $display("FAIL reach access: got penable=0 expected 1 within 50 cycles");
            $fatal(1, "access bound expired");
        end
        #2 ARESETn = 1'b0;
        @(negedge ACLK);
        #2 ARESETn = 1'b1;
        repeat (6) @(posedge ACLK);
        #1;
        issue(1'b1, 32'h0000_6004, 32'h01020304, 1, 1'b0, $urandom);
        drain();

        repeat (2) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
